// File: rtl/syn_i2s_dac_tx.sv
// I2S master transmitter for the WM8731 DAC: one-entry PCM holding buffer, BCLK/LRC generation, MSB-first serialiser.
// Optional underrun counter (dac_underrun_cnt / dac_underrun_clr) enabled by defining SYN_I2S_DAC_UNDERRUN_CNT_EN.
module syn_i2s_dac_tx #(
    parameter int DATA_W   = 16,
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 8
) (
    input  logic                acortex_clk,
    input  logic                acortex_rst,
    input  logic                dac_en,
    input  logic                pcm_valid,
    output logic                pcm_rdy,
    input  logic [2*DATA_W-1:0] pcm_data,
    output logic                AUD_BCLK,
    output logic                AUD_DACLRCK,
    output logic                AUD_DACDAT,
    output logic                dac_underrun
`ifdef SYN_I2S_DAC_UNDERRUN_CNT_EN
    ,
    input  logic                dac_underrun_clr,
    output logic [15:0]         dac_underrun_cnt
`endif
);

    localparam int FRAME_W = 2 * SLOT_W;
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam int DIV_W   = $clog2(BCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_TC    = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_TC    = BIT_W'(FRAME_W - 1);
    localparam logic [BIT_W-1:0] BIT_RSLOT = BIT_W'(SLOT_W);

    // ST_IDLE: pins parked | ST_START: running, first fall starts a frame | ST_RUN: framing on bit_cnt
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_RUN
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                bclk_q, bclk_d;
    logic                lrc_q, lrc_d;
    logic                dat_q, dat_d;
    logic                underrun_q, underrun_d;
    logic [2*DATA_W-1:0] buf_q, buf_d;
    logic                buf_full_q, buf_full_d;
    logic [DATA_W-1:0]   right_q, right_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [BIT_W-1:0]    bit_nxt;
    logic                accept;
    logic                tick;

    assign pcm_rdy      = ~buf_full_q & ~acortex_rst;
    assign accept       = pcm_valid & pcm_rdy;
    assign tick         = (div_cnt_q == DIV_TC);
    assign bit_nxt      = bit_cnt_q + 1'b1;

    assign AUD_BCLK     = bclk_q;
    assign AUD_DACLRCK  = lrc_q;
    assign AUD_DACDAT   = dat_q;
    assign dac_underrun = underrun_q;

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        bclk_d     = bclk_q;
        lrc_d      = lrc_q;
        dat_d      = dat_q;
        underrun_d = 1'b0;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        right_d    = right_q;
        shift_d    = shift_q;

        // accept is only possible while empty, so it never collides with a buffer load below
        if (accept) begin
            buf_d      = pcm_data;
            buf_full_d = 1'b1;
        end

        if (!dac_en) begin
            state_d   = ST_IDLE;
            div_cnt_d = '0;
            bit_cnt_d = '0;
            bclk_d    = 1'b0;
            lrc_d     = 1'b1;
            dat_d     = 1'b0;
            shift_d   = '0;
        end else begin
            if (state_q == ST_IDLE) begin
                state_d = ST_START;
            end
            if (tick) begin
                div_cnt_d = '0;
                bclk_d    = ~bclk_q;
                if (bclk_q) begin
                    if (state_q == ST_START || bit_cnt_q == BIT_TC) begin
                        state_d   = ST_RUN;
                        bit_cnt_d = '0;
                        lrc_d     = 1'b0;
                        dat_d     = 1'b0;
                        if (buf_full_q) begin
                            shift_d    = buf_q[2*DATA_W-1:DATA_W];
                            right_d    = buf_q[DATA_W-1:0];
                            buf_full_d = 1'b0;
                        end else begin
                            shift_d    = '0;
                            right_d    = '0;
                            underrun_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_nxt;
                        if (bit_nxt == BIT_RSLOT) begin
                            // right slot begins with its own delay bit
                            lrc_d   = 1'b1;
                            dat_d   = 1'b0;
                            shift_d = right_q;
                        end else begin
                            dat_d   = shift_q[DATA_W-1];
                            shift_d = {shift_q[DATA_W-2:0], 1'b0};
                        end
                    end
                end
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge acortex_clk) begin
        if (acortex_rst) begin
            state_q    <= ST_IDLE;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            bclk_q     <= 1'b0;
            lrc_q      <= 1'b1;
            dat_q      <= 1'b0;
            underrun_q <= 1'b0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            right_q    <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            bclk_q     <= bclk_d;
            lrc_q      <= lrc_d;
            dat_q      <= dat_d;
            underrun_q <= underrun_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            right_q    <= right_d;
            shift_q    <= shift_d;
        end
    end

`ifdef SYN_I2S_DAC_UNDERRUN_CNT_EN
    logic [15:0] ur_cnt_q, ur_cnt_d;

    // clear wins over a coincident pulse; count saturates
    always_comb begin
        ur_cnt_d = ur_cnt_q;
        if (dac_underrun_clr) begin
            ur_cnt_d = '0;
        end else if (underrun_q && (ur_cnt_q != 16'hFFFF)) begin
            ur_cnt_d = ur_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge acortex_clk) begin
        if (acortex_rst) begin
            ur_cnt_q <= '0;
        end else begin
            ur_cnt_q <= ur_cnt_d;
        end
    end

    assign dac_underrun_cnt = ur_cnt_q;
`else
    // underrun counter not built
`endif

endmodule
